axi_lite_regfile: RTL and testbench

//  AXI4-Lite responder: a bank of NREGS 32-bit registers at the far end of an address adaptor.

---
 rtl/axi_lite_regfile_pkg.sv | 27 ++
 rtl/axi_lite_hold_slot.sv | 43 ++++
 rtl/axi_lite_regfile.sv | 158 +++++++++++++++
 tb/tb_axi_lite_regfile.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_regfile_pkg.sv
// Shared AXI4-Lite definitions for the register-file responder:
// bus widths, response codes and the byte-strobe merge helper.
package axi_lite_regfile_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    function automatic logic [AXI_DATA_W-1:0] strb_merge(
        input logic [AXI_DATA_W-1:0] old_v,
        input logic [AXI_DATA_W-1:0] new_v,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] r;
        r = old_v;
        for (int unsigned k = 0; k < AXI_STRB_W; k++) begin
            if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_hold_slot.sv
// One-entry holding register: loads on valid&ready, clears on consume,
// and reports whether it currently holds an entry.
module axi_lite_hold_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         consume,
    output logic         held,
    output logic [W-1:0] out_data
);

    logic         held_q, held_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        held_d = held_q;
        data_d = data_q;
        if (consume) held_d = 1'b0;
        if (in_valid && !held_q) begin
            held_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            held_q <= 1'b0;
            data_q <= '0;
        end else begin
            held_q <= held_d;
            data_q <= data_d;
        end
    end

    assign in_ready = !held_q;
    assign held     = held_q;
    assign out_data = data_q;

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register bank: NREGS x 32-bit registers with byte strobes,
// read-only slots mirroring ro_in, and per-register write pulses.
module axi_lite_regfile
    import axi_lite_regfile_pkg::*;
#(
    parameter int unsigned      NREGS       = 16,
    parameter logic [31:0]      RESET_VALUE = 32'h0,
    parameter logic [NREGS-1:0] RO_MASK     = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [AXI_ADDR_W-1:0]   s_araddr,
    output logic                    s_arready,
    input  logic                    s_arvalid,
    input  logic [2:0]              s_arprot,
    output logic [AXI_DATA_W-1:0]   s_rdata,
    input  logic                    s_rready,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic [AXI_ADDR_W-1:0]   s_awaddr,
    output logic                    s_awready,
    input  logic                    s_awvalid,
    input  logic [2:0]              s_awprot,
    input  logic [AXI_DATA_W-1:0]   s_wdata,
    output logic                    s_wready,
    input  logic [AXI_STRB_W-1:0]   s_wstrb,
    input  logic                    s_wvalid,
    input  logic                    s_bready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    output logic [32*NREGS-1:0]     reg_out,
    input  logic [32*NREGS-1:0]     ro_in,
    output logic [NREGS-1:0]        wr_pulse
);

    logic                             aw_held, w_held, commit;
    logic [AXI_ADDR_W-1:0]            aw_addr;
    logic [AXI_STRB_W+AXI_DATA_W-1:0] w_slot;
    logic [29:0]                      aw_idx, ar_idx;

    logic [31:0]      regs_q [NREGS];
    logic [31:0]      regs_d [NREGS];
    logic [31:0]      cur_val [NREGS];
    logic [NREGS-1:0] wr_pulse_q, wr_pulse_d;
    logic             bvalid_q, bvalid_d;
    resp_e            bresp_q, bresp_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    resp_e            rresp_q, rresp_d;

    logic unused_bits;
    assign unused_bits = ^{s_arprot, s_awprot, s_araddr[1:0], aw_addr[1:0]};

    axi_lite_hold_slot #(.W(AXI_ADDR_W)) u_aw_slot (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (s_awvalid),
        .in_ready (s_awready),
        .in_data  (s_awaddr),
        .consume  (commit),
        .held     (aw_held),
        .out_data (aw_addr)
    );

    axi_lite_hold_slot #(.W(AXI_STRB_W + AXI_DATA_W)) u_w_slot (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (s_wvalid),
        .in_ready (s_wready),
        .in_data  ({s_wstrb, s_wdata}),
        .consume  (commit),
        .held     (w_held),
        .out_data (w_slot)
    );

    assign commit = aw_held && w_held && !bvalid_q;
    assign aw_idx = aw_addr[31:2];
    assign ar_idx = s_araddr[31:2];

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            cur_val[i]          = RO_MASK[i] ? ro_in[32*i +: 32] : regs_q[i];
            reg_out[32*i +: 32] = cur_val[i];
        end
    end

    // Write commit: an unmatched index falls through as SLVERR with no side effects.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        if (bvalid_q && s_bready) bvalid_d = 1'b0;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (aw_idx == 30'(i)) begin
                    bresp_d = RESP_OKAY;
                    if (!RO_MASK[i]) begin
                        regs_d[i]     = strb_merge(regs_q[i], w_slot[AXI_DATA_W-1:0],
                                                   w_slot[AXI_STRB_W+AXI_DATA_W-1:AXI_DATA_W]);
                        wr_pulse_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Reads sample regs_q, so a same-edge commit is not visible to the capture.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && s_rready) rvalid_d = 1'b0;
        if (s_arvalid && !rvalid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (ar_idx == 30'(i)) begin
                    rdata_d = cur_val[i];
                    rresp_d = RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= RESET_VALUE;
            wr_pulse_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_arready = !rvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign wr_pulse  = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed self-checking bench for axi_lite_regfile (NREGS=16, reg 1 read-only).
module tb_axi_lite_regfile;

    localparam int unsigned NREGS = 16;

    logic               clk, rstn;
    logic [31:0]        s_araddr, s_rdata, s_awaddr, s_wdata;
    logic               s_arready, s_arvalid, s_rready, s_rvalid;
    logic [2:0]         s_arprot, s_awprot;
    logic [1:0]         s_rresp, s_bresp;
    logic               s_awready, s_awvalid, s_wready, s_wvalid, s_bready, s_bvalid;
    logic [3:0]         s_wstrb;
    logic [32*NREGS-1:0] reg_out, ro_in;
    logic [NREGS-1:0]   wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model [NREGS];

    axi_lite_regfile #(
        .NREGS       (NREGS),
        .RESET_VALUE (32'h0),
        .RO_MASK     (16'h0002)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_araddr(s_araddr), .s_arready(s_arready), .s_arvalid(s_arvalid), .s_arprot(s_arprot),
        .s_rdata(s_rdata), .s_rready(s_rready), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_awaddr(s_awaddr), .s_awready(s_awready), .s_awvalid(s_awvalid), .s_awprot(s_awprot),
        .s_wdata(s_wdata), .s_wready(s_wready), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
        .s_bready(s_bready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [32*NREGS-1:0] exp_regout();
        logic [32*NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[32*i +: 32] = (i == 1) ? ro_in[63:32] : model[i];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                            output logic [1:0] resp, output logic [15:0] pulse, output bit ok);
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        ok = 1'b0; resp = 2'b11; pulse = '1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (s_bvalid) begin
                resp = s_bresp; pulse = wr_pulse; ok = 1'b1;
                break;
            end
        end
        step();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                           output int cyc, output bit ok);
        s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
        ok = 1'b0; data = 32'hx; resp = 2'b11; cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (s_rvalid) begin
                data = s_rdata; resp = s_rresp; cyc = c; ok = 1'b1;
                break;
            end
        end
        s_arvalid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step(); step();
        for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
        n_checks++; if (reg_out !== exp_regout()) begin n_fail++;
            $display("FAIL reset_regs: got %h want %h", reg_out, exp_regout()); end
        n_checks++; if ({s_arready, s_awready, s_wready, s_rvalid, s_bvalid} !== 5'b11100) begin n_fail++;
            $display("FAIL reset_hs: got %b want 11100", {s_arready, s_awready, s_wready, s_rvalid, s_bvalid}); end
        n_checks++; if ({wr_pulse, s_rdata, s_rresp, s_bresp} !== '0) begin n_fail++;
            $display("FAIL reset_out: pulse %h rdata %h rresp %b bresp %b want 0", wr_pulse, s_rdata, s_rresp, s_bresp); end
        rstn = 1'b1;
    endtask

    task automatic test_reset_discard();
        s_awaddr = 32'h18; s_awvalid = 1'b1;
        step();
        s_awvalid = 1'b0; rstn = 1'b0;
        step();
        rstn = 1'b1;
        n_checks++; if (s_awready !== 1'b1) begin n_fail++;
            $display("FAIL discard_awready: got %b want 1", s_awready); end
        s_wdata = 32'h0000_0077; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
        step();
        s_wvalid = 1'b0;
        step(); step();
        n_checks++; if ({s_bvalid, s_awready, s_wready} !== 3'b010) begin n_fail++;
            $display("FAIL discard_nocommit: bvalid/awready/wready got %b want 010", {s_bvalid, s_awready, s_wready}); end
        s_awaddr = 32'h18; s_awvalid = 1'b1;
        step();
        s_awvalid = 1'b0;
        step();
        model[6] = 32'h0000_0077;
        n_checks++; if ({s_bvalid, wr_pulse} !== {1'b1, 16'h0040}) begin n_fail++;
            $display("FAIL discard_commit: bvalid/pulse got %b/%h want 1/0040", s_bvalid, wr_pulse); end
        s_bready = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic [1:0] r; int cyc; bit ok;
        s_awaddr = 32'h08; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n_checks++; if (s_bvalid !== 1'b0) begin n_fail++;
            $display("FAIL wr_bvalid_early: got %b want 0", s_bvalid); end
        step();
        model[2] = 32'hDEAD_BEEF;
        n_checks++; if ({s_bvalid, s_bresp, wr_pulse} !== {1'b1, 2'b00, 16'h0004}) begin n_fail++;
            $display("FAIL wr_b: bvalid/bresp/pulse got %b/%b/%h want 1/00/0004", s_bvalid, s_bresp, wr_pulse); end
        n_checks++; if (reg_out !== exp_regout()) begin n_fail++;
            $display("FAIL wr_regs: got %h want %h", reg_out, exp_regout()); end
        step();
        n_checks++; if ({s_bvalid, wr_pulse} !== 17'h0) begin n_fail++;
            $display("FAIL wr_after: bvalid/pulse got %b/%h want 0/0000", s_bvalid, wr_pulse); end
        do_read(32'h08, d, r, cyc, ok);
        n_checks++; if ({ok, d, r} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin n_fail++;
            $display("FAIL rd_08: ok/data/resp got %b/%h/%b want 1/deadbeef/00", ok, d, r); end
        n_checks++; if (cyc !== 1) begin n_fail++;
            $display("FAIL rd_latency: got %0d want 1", cyc); end
    endtask

    task automatic test_strobe_order();
        logic [1:0] r; logic [15:0] p; bit ok;
        do_write(32'h0C, 32'h1122_3344, 4'hF, r, p, ok);
        model[3] = 32'h1122_3344;
        n_checks++; if ({ok, r, p} !== {1'b1, 2'b00, 16'h0008}) begin n_fail++;
            $display("FAIL strb_pre: ok/resp/pulse got %b/%b/%h want 1/00/0008", ok, r, p); end
        s_wdata = 32'hAABB_CCDD; s_wstrb = 4'b0101; s_wvalid = 1'b1;
        step();
        s_wvalid = 1'b0;
        step(); step();
        n_checks++; if ({s_bvalid, s_awready, s_wready} !== 3'b010) begin n_fail++;
            $display("FAIL strb_wait: bvalid/awready/wready got %b want 010", {s_bvalid, s_awready, s_wready}); end
        s_awaddr = 32'h0C; s_awvalid = 1'b1;
        step();
        s_awvalid = 1'b0;
        step();
        model[3] = 32'h11BB_33DD;
        n_checks++; if ({s_bvalid, s_bresp, wr_pulse} !== {1'b1, 2'b00, 16'h0008}) begin n_fail++;
            $display("FAIL strb_b: bvalid/bresp/pulse got %b/%b/%h want 1/00/0008", s_bvalid, s_bresp, wr_pulse); end
        n_checks++; if (reg_out[127:96] !== 32'h11BB_33DD) begin n_fail++;
            $display("FAIL strb_merge: got %h want 11bb33dd", reg_out[127:96]); end
        step();
    endtask

    task automatic test_range();
        logic [31:0] d; logic [1:0] r; logic [15:0] p; int cyc; bit ok;
        do_write(32'h40, 32'h1234_5678, 4'hF, r, p, ok);
        n_checks++; if ({ok, r, p} !== {1'b1, 2'b10, 16'h0000}) begin n_fail++;
            $display("FAIL range_wr: ok/resp/pulse got %b/%b/%h want 1/10/0000", ok, r, p); end
        n_checks++; if (reg_out !== exp_regout()) begin n_fail++;
            $display("FAIL range_regs: got %h want %h", reg_out, exp_regout()); end
        do_read(32'h7C, d, r, cyc, ok);
        n_checks++; if ({ok, d, r} !== {1'b1, 32'h0, 2'b10}) begin n_fail++;
            $display("FAIL range_rd: ok/data/resp got %b/%h/%b want 1/00000000/10", ok, d, r); end
        do_read(32'h0B, d, r, cyc, ok);
        n_checks++; if ({ok, d, r} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin n_fail++;
            $display("FAIL range_lowbits: ok/data/resp got %b/%h/%b want 1/deadbeef/00", ok, d, r); end
    endtask

    task automatic test_backpressure();
        s_bready = 1'b0;
        s_awaddr = 32'h10; s_wdata = 32'h0101_0101; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        step();
        model[4] = 32'h0101_0101;
        n_checks++; if ({s_bvalid, s_bresp, wr_pulse} !== {1'b1, 2'b00, 16'h0010}) begin n_fail++;
            $display("FAIL bp_first: bvalid/bresp/pulse got %b/%b/%h want 1/00/0010", s_bvalid, s_bresp, wr_pulse); end
        s_awaddr = 32'h14; s_wdata = 32'h0202_0202; s_awvalid = 1'b1; s_wvalid = 1'b1;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n_checks++; if ({s_awready, s_wready} !== 2'b00) begin n_fail++;
            $display("FAIL bp_slots: awready/wready got %b want 00", {s_awready, s_wready}); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if ({s_bvalid, s_bresp, wr_pulse} !== {1'b1, 2'b00, 16'h0000}) begin n_fail++;
                $display("FAIL bp_hold[%0d]: bvalid/bresp/pulse got %b/%b/%h want 1/00/0000", i, s_bvalid, s_bresp, wr_pulse); end
        end
        n_checks++; if (reg_out !== exp_regout()) begin n_fail++;
            $display("FAIL bp_nocommit: got %h want %h", reg_out, exp_regout()); end
        s_bready = 1'b1;
        step();
        n_checks++; if (s_bvalid !== 1'b0) begin n_fail++;
            $display("FAIL bp_release: bvalid got %b want 0", s_bvalid); end
        step();
        model[5] = 32'h0202_0202;
        n_checks++; if ({s_bvalid, wr_pulse, reg_out} !== {1'b1, 16'h0020, exp_regout()}) begin n_fail++;
            $display("FAIL bp_second: bvalid/pulse got %b/%h regs %h", s_bvalid, wr_pulse, reg_out); end
        step();
        s_rready = 1'b0; s_araddr = 32'h10; s_arvalid = 1'b1;
        step();
        s_araddr = 32'h14;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({s_rvalid, s_arready, s_rdata, s_rresp} !== {1'b1, 1'b0, 32'h0101_0101, 2'b00}) begin n_fail++;
                $display("FAIL rbp_hold[%0d]: rvalid/arready/rdata/rresp got %b/%b/%h/%b want 1/0/01010101/00", i, s_rvalid, s_arready, s_rdata, s_rresp); end
            step();
        end
        s_arvalid = 1'b0; s_rready = 1'b1;
        step();
        n_checks++; if ({s_rvalid, s_arready} !== 2'b01) begin n_fail++;
            $display("FAIL rbp_release: rvalid/arready got %b want 01", {s_rvalid, s_arready}); end
    endtask

    task automatic test_ro_collision();
        logic [31:0] d; logic [1:0] r; logic [15:0] p; int cyc; bit ok;
        ro_in[63:32] = 32'hCAFE_0001;
        #1;
        n_checks++; if (reg_out[63:32] !== 32'hCAFE_0001) begin n_fail++;
            $display("FAIL ro_mirror: got %h want cafe0001", reg_out[63:32]); end
        do_write(32'h04, 32'hFFFF_FFFF, 4'hF, r, p, ok);
        n_checks++; if ({ok, r, p, reg_out} !== {1'b1, 2'b00, 16'h0000, exp_regout()}) begin n_fail++;
            $display("FAIL ro_write: ok/resp/pulse got %b/%b/%h regs %h", ok, r, p, reg_out); end
        do_read(32'h04, d, r, cyc, ok);
        n_checks++; if ({ok, d, r} !== {1'b1, 32'hCAFE_0001, 2'b00}) begin n_fail++;
            $display("FAIL ro_read: ok/data/resp got %b/%h/%b want 1/cafe0001/00", ok, d, r); end
        s_awaddr = 32'h08; s_wdata = 32'h5566_7788; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 32'h08; s_arvalid = 1'b1; s_rready = 1'b0;
        step();
        s_arvalid = 1'b0;
        model[2] = 32'h5566_7788;
        n_checks++; if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin n_fail++;
            $display("FAIL collide_rd: rvalid/rdata/rresp got %b/%h/%b want 1/deadbeef/00", s_rvalid, s_rdata, s_rresp); end
        n_checks++; if ({s_bvalid, reg_out} !== {1'b1, exp_regout()}) begin n_fail++;
            $display("FAIL collide_wr: bvalid got %b regs %h want %h", s_bvalid, reg_out, exp_regout()); end
        s_rready = 1'b1;
        step();
        n_checks++; if ({s_rvalid, s_bvalid} !== 2'b00) begin n_fail++;
            $display("FAIL collide_done: rvalid/bvalid got %b want 00", {s_rvalid, s_bvalid}); end
    endtask

    initial begin
        rstn = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_arprot = 3'b111; s_rready = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_awprot = 3'b101;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        ro_in = '0;
        test_reset();
        test_reset_discard();
        test_write_read();
        test_strobe_order();
        test_range();
        test_backpressure();
        test_ro_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
